// File: rtl/control_path.sv
`default_nettype none
// ============================================================================
// Module   : control_path
// Purpose  : RV32I 5-stage pipeline control: decode, EX/MEM/WB control
//            registers, forwarding selects and stall/flush/redirect logic.
// Revision : 1.0 - initial release
// ============================================================================
module control_path (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instruction_i,
    input  logic        branch_condition_i,
    output logic        mem_to_reg_o,
    output logic [4:0]  alu_op_o,
    output logic        alu_src_b_o,
    output logic        rd_we_o,
    output logic        pc_next_sel_o,
    output logic        pc_operand_o,
    output logic [3:0]  data_mem_we_o,
    output logic [1:0]  alu_forward_a_o,
    output logic [1:0]  alu_forward_b_o,
    output logic        branch_forward_a_o,
    output logic        branch_forward_b_o,
    output logic        if_id_flush_o,
    output logic        pc_en_o,
    output logic        if_id_en_o
);

    localparam logic [6:0] c_OP_R      = 7'b0110011;
    localparam logic [6:0] c_OP_IMM    = 7'b0010011;
    localparam logic [6:0] c_OP_LUI    = 7'b0110111;
    localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OP_STORE  = 7'b0100011;
    localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
    localparam logic [6:0] c_OP_JAL    = 7'b1101111;
    localparam logic [6:0] c_OP_JALR   = 7'b1100111;

    localparam logic [4:0] c_ALU_ADD   = 5'd0;
    localparam logic [4:0] c_ALU_SUB   = 5'd1;
    localparam logic [4:0] c_ALU_SLL   = 5'd2;
    localparam logic [4:0] c_ALU_SLT   = 5'd3;
    localparam logic [4:0] c_ALU_SLTU  = 5'd4;
    localparam logic [4:0] c_ALU_XOR   = 5'd5;
    localparam logic [4:0] c_ALU_SRL   = 5'd6;
    localparam logic [4:0] c_ALU_SRA   = 5'd7;
    localparam logic [4:0] c_ALU_OR    = 5'd8;
    localparam logic [4:0] c_ALU_AND   = 5'd9;
    localparam logic [4:0] c_ALU_PASSB = 5'd10;

    function automatic logic [4:0] f_alu_op(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  f_alu_op = alt ? c_ALU_SUB : c_ALU_ADD;
            3'b001:  f_alu_op = c_ALU_SLL;
            3'b010:  f_alu_op = c_ALU_SLT;
            3'b011:  f_alu_op = c_ALU_SLTU;
            3'b100:  f_alu_op = c_ALU_XOR;
            3'b101:  f_alu_op = alt ? c_ALU_SRA : c_ALU_SRL;
            3'b110:  f_alu_op = c_ALU_OR;
            default: f_alu_op = c_ALU_AND;
        endcase
    endfunction

    logic [6:0] w_opcode;
    logic [2:0] w_funct3;
    logic [4:0] w_alu_op, w_src1, w_src2, w_dst;
    logic [3:0] w_mem_we;
    logic       w_src_b, w_m2r, w_we, w_is_load, w_is_branch, w_is_jal, w_is_jalr;
    logic       w_use_rs1, w_use_rs2;
    logic       w_unused;

    assign w_opcode = instruction_i[6:0];
    assign w_funct3 = instruction_i[14:12];
    assign w_unused = ^{instruction_i[31], instruction_i[29:25]};

    always_comb begin
        w_alu_op    = c_ALU_ADD;
        w_mem_we    = 4'b0000;
        w_src_b     = 1'b0;
        w_m2r       = 1'b0;
        w_we        = 1'b0;
        w_is_load   = 1'b0;
        w_is_branch = 1'b0;
        w_is_jal    = 1'b0;
        w_is_jalr   = 1'b0;
        w_use_rs1   = 1'b0;
        w_use_rs2   = 1'b0;
        case (w_opcode)
            c_OP_R: begin
                w_alu_op  = f_alu_op(w_funct3, instruction_i[30]);
                w_we      = 1'b1;
                w_use_rs1 = 1'b1;
                w_use_rs2 = 1'b1;
            end
            c_OP_IMM: begin
                // bit 30 is immediate data except for the SRLI/SRAI split
                w_alu_op  = f_alu_op(w_funct3, instruction_i[30] && (w_funct3 == 3'b101));
                w_src_b   = 1'b1;
                w_we      = 1'b1;
                w_use_rs1 = 1'b1;
            end
            c_OP_LUI: begin
                w_alu_op = c_ALU_PASSB;
                w_src_b  = 1'b1;
                w_we     = 1'b1;
            end
            c_OP_LOAD: begin
                if (w_funct3 == 3'b010) begin
                    w_src_b   = 1'b1;
                    w_m2r     = 1'b1;
                    w_we      = 1'b1;
                    w_is_load = 1'b1;
                    w_use_rs1 = 1'b1;
                end
            end
            c_OP_STORE: begin
                if (w_funct3 <= 3'b010) begin
                    w_mem_we  = (w_funct3 == 3'b000) ? 4'b0001 :
                                (w_funct3 == 3'b001) ? 4'b0011 : 4'b1111;
                    w_src_b   = 1'b1;
                    w_use_rs1 = 1'b1;
                    w_use_rs2 = 1'b1;
                end
            end
            c_OP_BRANCH: begin
                if (w_funct3[2:1] != 2'b01) begin
                    w_is_branch = 1'b1;
                    w_use_rs1   = 1'b1;
                    w_use_rs2   = 1'b1;
                end
            end
            c_OP_JAL: w_is_jal = 1'b1;
            c_OP_JALR: begin
                if (w_funct3 == 3'b000) begin
                    w_is_jalr = 1'b1;
                    w_use_rs1 = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Register indices are zeroed when unused/unwritten, so a nonzero
    // match below already implies "really read" and "really written".
    assign w_src1 = w_use_rs1 ? instruction_i[19:15] : 5'd0;
    assign w_src2 = w_use_rs2 ? instruction_i[24:20] : 5'd0;
    assign w_dst  = w_we      ? instruction_i[11:7]  : 5'd0;

    logic [4:0] r_ex_alu_op, r_ex_rs1, r_ex_rs2, r_ex_rd, r_mem_rd, r_wb_rd;
    logic [3:0] r_ex_mem_we, r_mem_mem_we;
    logic       r_ex_src_b, r_ex_m2r, r_ex_we, r_ex_is_load;
    logic       r_mem_m2r, r_mem_we, r_mem_is_load, r_wb_m2r, r_wb_we;

    logic w_xfer, w_ex_hit1, w_ex_hit2, w_mem_hit1, w_mem_hit2, w_stall, w_redirect;

    assign w_xfer     = w_is_branch || w_is_jalr;
    assign w_ex_hit1  = (r_ex_rd  != 5'd0) && (w_src1 == r_ex_rd);
    assign w_ex_hit2  = (r_ex_rd  != 5'd0) && (w_src2 == r_ex_rd);
    assign w_mem_hit1 = (r_mem_rd != 5'd0) && (w_src1 == r_mem_rd);
    assign w_mem_hit2 = (r_mem_rd != 5'd0) && (w_src2 == r_mem_rd);

    assign w_stall = (r_ex_is_load && (w_ex_hit1 || w_ex_hit2)) ||
                     (w_xfer && (w_ex_hit1 || w_ex_hit2)) ||
                     (w_xfer && r_mem_is_load && (w_mem_hit1 || w_mem_hit2));

    assign w_redirect = !w_stall && (w_is_jal || w_is_jalr || (w_is_branch && branch_condition_i));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ex_alu_op   <= 5'd0;
            r_ex_src_b    <= 1'b0;
            r_ex_m2r      <= 1'b0;
            r_ex_we       <= 1'b0;
            r_ex_mem_we   <= 4'b0000;
            r_ex_is_load  <= 1'b0;
            r_ex_rs1      <= 5'd0;
            r_ex_rs2      <= 5'd0;
            r_ex_rd       <= 5'd0;
            r_mem_m2r     <= 1'b0;
            r_mem_we      <= 1'b0;
            r_mem_mem_we  <= 4'b0000;
            r_mem_is_load <= 1'b0;
            r_mem_rd      <= 5'd0;
            r_wb_m2r      <= 1'b0;
            r_wb_we       <= 1'b0;
            r_wb_rd       <= 5'd0;
        end else begin
            r_ex_alu_op   <= w_stall ? 5'd0    : w_alu_op;
            r_ex_src_b    <= w_stall ? 1'b0    : w_src_b;
            r_ex_m2r      <= w_stall ? 1'b0    : w_m2r;
            r_ex_we       <= w_stall ? 1'b0    : w_we;
            r_ex_mem_we   <= w_stall ? 4'b0000 : w_mem_we;
            r_ex_is_load  <= w_stall ? 1'b0    : w_is_load;
            r_ex_rs1      <= w_stall ? 5'd0    : w_src1;
            r_ex_rs2      <= w_stall ? 5'd0    : w_src2;
            r_ex_rd       <= w_stall ? 5'd0    : w_dst;
            r_mem_m2r     <= r_ex_m2r;
            r_mem_we      <= r_ex_we;
            r_mem_mem_we  <= r_ex_mem_we;
            r_mem_is_load <= r_ex_is_load;
            r_mem_rd      <= r_ex_rd;
            r_wb_m2r      <= r_mem_m2r;
            r_wb_we       <= r_mem_we;
            r_wb_rd       <= r_mem_rd;
        end
    end

    assign alu_forward_a_o = ((r_ex_rs1 != 5'd0) && (r_ex_rs1 == r_mem_rd)) ? 2'b10 :
                             ((r_ex_rs1 != 5'd0) && (r_ex_rs1 == r_wb_rd))  ? 2'b01 : 2'b00;
    assign alu_forward_b_o = ((r_ex_rs2 != 5'd0) && (r_ex_rs2 == r_mem_rd)) ? 2'b10 :
                             ((r_ex_rs2 != 5'd0) && (r_ex_rs2 == r_wb_rd))  ? 2'b01 : 2'b00;

    assign branch_forward_a_o = w_xfer && w_mem_hit1 && !r_mem_is_load;
    assign branch_forward_b_o = w_xfer && w_mem_hit2 && !r_mem_is_load;

    assign alu_op_o      = r_ex_alu_op;
    assign alu_src_b_o   = r_ex_src_b;
    assign data_mem_we_o = r_mem_mem_we;
    assign mem_to_reg_o  = r_wb_m2r;
    assign rd_we_o       = r_wb_we;
    assign pc_next_sel_o = w_redirect;
    assign if_id_flush_o = w_redirect;
    assign pc_operand_o  = w_is_jalr;
    assign pc_en_o       = !w_stall;
    assign if_id_en_o    = !w_stall;

endmodule
`default_nettype wire

// File: tb/tb_control_path.sv
`default_nettype none
// ============================================================================
// Module   : tb_control_path
// Purpose  : Self-checking bench for control_path (vector table, directed
//            sequences, random stream against an instruction-level model).
// Revision : 1.0 - initial release
// ============================================================================
module tb_control_path;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] instruction_i = 32'h0;
    logic        branch_condition_i = 1'b0;
    logic        mem_to_reg_o, alu_src_b_o, rd_we_o, pc_next_sel_o, pc_operand_o;
    logic [4:0]  alu_op_o;
    logic [3:0]  data_mem_we_o;
    logic [1:0]  alu_forward_a_o, alu_forward_b_o;
    logic        branch_forward_a_o, branch_forward_b_o, if_id_flush_o, pc_en_o, if_id_en_o;

    control_path dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .instruction_i      (instruction_i),
        .branch_condition_i (branch_condition_i),
        .mem_to_reg_o       (mem_to_reg_o),
        .alu_op_o           (alu_op_o),
        .alu_src_b_o        (alu_src_b_o),
        .rd_we_o            (rd_we_o),
        .pc_next_sel_o      (pc_next_sel_o),
        .pc_operand_o       (pc_operand_o),
        .data_mem_we_o      (data_mem_we_o),
        .alu_forward_a_o    (alu_forward_a_o),
        .alu_forward_b_o    (alu_forward_b_o),
        .branch_forward_a_o (branch_forward_a_o),
        .branch_forward_b_o (branch_forward_b_o),
        .if_id_flush_o      (if_id_flush_o),
        .pc_en_o            (pc_en_o),
        .if_id_en_o         (if_id_en_o)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- instruction-level reference model ----------------
    typedef struct packed {
        logic [4:0] alu;
        logic       srcb, m2r, we, ld, br, jal, jalr, r1, r2;
        logic [3:0] mwe;
        logic [4:0] rs1, rs2, rd;
    } dec_t;

    function automatic dec_t dec(input logic [31:0] w);
        dec_t d;
        int unsigned base [8];
        logic [6:0] op;
        logic [2:0] f3;
        base = '{0, 2, 3, 4, 5, 6, 8, 9};
        op = w[6:0];
        f3 = w[14:12];
        d = '0;
        d.rs1 = w[19:15];
        d.rs2 = w[24:20];
        d.rd  = w[11:7];
        if (op == 7'h33 || op == 7'h13) begin
            d.we = 1; d.r1 = 1; d.r2 = (op == 7'h33); d.srcb = (op == 7'h13);
            // SUB follows ADD and SRA follows SRL in the opcode numbering
            d.alu = 5'(base[f3] + ((w[30] && (f3 == 5 || (f3 == 0 && op == 7'h33))) ? 1 : 0));
        end else if (op == 7'h37) begin
            d.we = 1; d.srcb = 1; d.alu = 5'd10;
        end else if (op == 7'h03 && f3 == 2) begin
            d.we = 1; d.srcb = 1; d.m2r = 1; d.ld = 1; d.r1 = 1;
        end else if (op == 7'h23 && f3 <= 2) begin
            d.srcb = 1; d.r1 = 1; d.r2 = 1;
            d.mwe = 4'((1 << (1 << f3)) - 1);
        end else if (op == 7'h63 && f3 != 2 && f3 != 3) begin
            d.br = 1; d.r1 = 1; d.r2 = 1;
        end else if (op == 7'h6F) begin
            d.jal = 1;
        end else if (op == 7'h67 && f3 == 0) begin
            d.jalr = 1; d.r1 = 1;
        end
        return d;
    endfunction

    logic [31:0] m_ex = 32'h0, m_mem = 32'h0, m_wb = 32'h0;

    function automatic logic reads(input logic [4:0] x, input dec_t d);
        return (x != 0) && ((d.r1 && d.rs1 == x) || (d.r2 && d.rs2 == x));
    endfunction

    function automatic logic exp_stall();
        dec_t id, ex, mm;
        id = dec(instruction_i); ex = dec(m_ex); mm = dec(m_mem);
        return (ex.ld && reads(ex.rd, id)) ||
               ((id.br || id.jalr) && ((ex.we && reads(ex.rd, id)) || (mm.ld && reads(mm.rd, id))));
    endfunction

    function automatic logic [1:0] exp_fwd(input logic used, input logic [4:0] rs);
        dec_t mm, wb;
        mm = dec(m_mem); wb = dec(m_wb);
        if (!used || rs == 0) return 2'b00;
        if (mm.we && mm.rd == rs) return 2'b10;
        if (wb.we && wb.rd == rs) return 2'b01;
        return 2'b00;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_ex <= 32'h0; m_mem <= 32'h0; m_wb <= 32'h0;
        end else begin
            m_wb  <= m_mem;
            m_mem <= m_ex;
            m_ex  <= exp_stall() ? 32'h0 : instruction_i;
        end
    end

    task automatic chk_all();
        dec_t id, ex, mm, wb;
        logic st, xfer, redir;
        id = dec(instruction_i); ex = dec(m_ex); mm = dec(m_mem); wb = dec(m_wb);
        st = exp_stall();
        xfer = id.br || id.jalr;
        redir = !st && (id.jal || id.jalr || (id.br && branch_condition_i));
        chk("alu_op", alu_op_o, ex.alu);
        chk("alu_src_b", alu_src_b_o, ex.srcb);
        chk("mem_we", data_mem_we_o, mm.mwe);
        chk("rd_we", rd_we_o, wb.we);
        chk("mem_to_reg", mem_to_reg_o, wb.m2r);
        chk("fwd_a", alu_forward_a_o, exp_fwd(ex.r1, ex.rs1));
        chk("fwd_b", alu_forward_b_o, exp_fwd(ex.r2, ex.rs2));
        chk("bfwd_a", branch_forward_a_o, xfer && id.r1 && id.rs1 != 0 && mm.we && !mm.ld && mm.rd == id.rs1);
        chk("bfwd_b", branch_forward_b_o, xfer && id.r2 && id.rs2 != 0 && mm.we && !mm.ld && mm.rd == id.rs2);
        chk("pc_en", pc_en_o, !st);
        chk("if_id_en", if_id_en_o, !st);
        chk("pc_next_sel", pc_next_sel_o, redir);
        chk("flush", if_id_flush_o, redir);
        chk("pc_operand", pc_operand_o, id.jalr);
    endtask

    // ---------------- encoders ----------------
    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'h33};
    endfunction
    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd, input logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction
    function automatic logic [31:0] enc_s(input logic [4:0] rs2, input logic [4:0] rs1, input logic [2:0] f3);
        return {7'h0, rs2, rs1, f3, 5'h0, 7'h23};
    endfunction
    function automatic logic [31:0] enc_b(input logic [4:0] rs2, input logic [4:0] rs1, input logic [2:0] f3);
        return {7'h0, rs2, rs1, f3, 5'h0, 7'h63};
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [4:0] a, b, d;
        a = 5'($urandom_range(0, 7)); b = 5'($urandom_range(0, 7)); d = 5'($urandom_range(0, 7));
        case ($urandom_range(0, 11))
            0, 10:   return enc_r({1'b0, 1'($urandom_range(0, 1)), 5'h0}, b, a, 3'($urandom), d);
            1:       return enc_i(12'($urandom), a, 3'($urandom), d, 7'h13);
            2:       return {20'($urandom), d, 7'h37};
            3, 11:   return enc_i(12'($urandom), a, 3'($urandom_range(0, 2)), d, 7'h03);
            4:       return enc_s(b, a, 3'($urandom_range(0, 3)));
            5:       return enc_b(b, a, 3'($urandom));
            6:       return {20'($urandom), d, 7'h6F};
            7:       return enc_i(12'($urandom), a, 3'($urandom_range(0, 1)), d, 7'h67);
            8:       return $urandom;
            default: return 32'h0;
        endcase
    endfunction

    task automatic drive(input logic [31:0] ins, input logic c);
        @(posedge clk);
        #1;
        instruction_i = ins;
        branch_condition_i = c;
        @(negedge clk);
        chk_all();
    endtask

    typedef struct {
        string       nm;
        logic [31:0] ins;
        logic [4:0]  alu;
        logic        srcb, m2r, we;
        logic [3:0]  mwe;
    } vec_t;

    function automatic vec_t mk(input string nm, input logic [31:0] ins, input logic [4:0] alu,
                                input logic srcb, input logic m2r, input logic we, input logic [3:0] mwe);
        vec_t v;
        v.nm = nm; v.ins = ins; v.alu = alu; v.srcb = srcb; v.m2r = m2r; v.we = we; v.mwe = mwe;
        return v;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        vec_t tbl [$];
        logic [31:0] cur;
        logic hold;
        tbl.push_back(mk("ADD",   enc_r(7'h00, 3, 2, 0, 1), 0, 0, 0, 1, 4'h0));
        tbl.push_back(mk("SUB",   enc_r(7'h20, 3, 2, 0, 1), 1, 0, 0, 1, 4'h0));
        tbl.push_back(mk("SLL",   enc_r(7'h00, 3, 2, 1, 1), 2, 0, 0, 1, 4'h0));
        tbl.push_back(mk("SLT",   enc_r(7'h00, 3, 2, 2, 1), 3, 0, 0, 1, 4'h0));
        tbl.push_back(mk("SLTU",  enc_r(7'h00, 3, 2, 3, 1), 4, 0, 0, 1, 4'h0));
        tbl.push_back(mk("XOR",   enc_r(7'h00, 3, 2, 4, 1), 5, 0, 0, 1, 4'h0));
        tbl.push_back(mk("SRL",   enc_r(7'h00, 3, 2, 5, 1), 6, 0, 0, 1, 4'h0));
        tbl.push_back(mk("SRA",   enc_r(7'h20, 3, 2, 5, 1), 7, 0, 0, 1, 4'h0));
        tbl.push_back(mk("OR",    enc_r(7'h00, 3, 2, 6, 1), 8, 0, 0, 1, 4'h0));
        tbl.push_back(mk("AND",   enc_r(7'h00, 3, 2, 7, 1), 9, 0, 0, 1, 4'h0));
        tbl.push_back(mk("ADDI-1", enc_i(12'hFFF, 2, 0, 4, 7'h13), 0, 1, 0, 1, 4'h0));
        tbl.push_back(mk("SRLI",  enc_i(12'h005, 2, 5, 4, 7'h13), 6, 1, 0, 1, 4'h0));
        tbl.push_back(mk("SRAI",  enc_i(12'h405, 2, 5, 4, 7'h13), 7, 1, 0, 1, 4'h0));
        tbl.push_back(mk("SLTIU", enc_i(12'h010, 2, 3, 4, 7'h13), 4, 1, 0, 1, 4'h0));
        tbl.push_back(mk("ANDI",  enc_i(12'h0F0, 2, 7, 4, 7'h13), 9, 1, 0, 1, 4'h0));
        tbl.push_back(mk("LUI",   {20'hABCDE, 5'd4, 7'h37}, 10, 1, 0, 1, 4'h0));
        tbl.push_back(mk("LW",    enc_i(12'h004, 1, 2, 7, 7'h03), 0, 1, 1, 1, 4'h0));
        tbl.push_back(mk("LH-ill", enc_i(12'h004, 1, 1, 7, 7'h03), 0, 0, 0, 0, 4'h0));
        tbl.push_back(mk("SB",    enc_s(2, 1, 0), 0, 1, 0, 0, 4'h1));
        tbl.push_back(mk("SH",    enc_s(2, 1, 1), 0, 1, 0, 0, 4'h3));
        tbl.push_back(mk("SW",    enc_s(2, 1, 2), 0, 1, 0, 0, 4'hF));
        tbl.push_back(mk("S3-ill", enc_s(2, 1, 3), 0, 0, 0, 0, 4'h0));
        tbl.push_back(mk("BEQ",   enc_b(2, 1, 0), 0, 0, 0, 0, 4'h0));
        tbl.push_back(mk("B2-ill", enc_b(2, 1, 2), 0, 0, 0, 0, 4'h0));
        tbl.push_back(mk("JAL",   {20'h00010, 5'd1, 7'h6F}, 0, 0, 0, 0, 4'h0));
        tbl.push_back(mk("JALR",  enc_i(12'h0, 3, 0, 1, 7'h67), 0, 0, 0, 0, 4'h0));
        tbl.push_back(mk("ILL7F", 32'h0000007F, 0, 0, 0, 0, 4'h0));

        // Reset held 3 clk with a live ADD in ID
        instruction_i = enc_r(7'h00, 3, 2, 0, 1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst alu_op", alu_op_o, 0);
        chk("rst alu_src_b", alu_src_b_o, 0);
        chk("rst mem_to_reg", mem_to_reg_o, 0);
        chk("rst rd_we", rd_we_o, 0);
        chk("rst mem_we", data_mem_we_o, 0);
        chk("rst fwd_a", alu_forward_a_o, 0);
        chk("rst fwd_b", alu_forward_b_o, 0);
        chk("rst bfwd_a", branch_forward_a_o, 0);
        chk("rst bfwd_b", branch_forward_b_o, 0);
        chk("rst pc_next_sel", pc_next_sel_o, 0);
        chk("rst flush", if_id_flush_o, 0);
        chk("rst pc_en", pc_en_o, 1);
        chk("rst if_id_en", if_id_en_o, 1);
        rst_n = 1'b1;

        // Decode table: instruction, then three bubbles to walk it to WB
        foreach (tbl[i]) begin
            drive(tbl[i].ins, 1'b0);
            drive(32'h0, 1'b0);
            chk({tbl[i].nm, " alu_op"}, alu_op_o, tbl[i].alu);
            chk({tbl[i].nm, " alu_src_b"}, alu_src_b_o, tbl[i].srcb);
            drive(32'h0, 1'b0);
            chk({tbl[i].nm, " mem_we"}, data_mem_we_o, tbl[i].mwe);
            drive(32'h0, 1'b0);
            chk({tbl[i].nm, " rd_we"}, rd_we_o, tbl[i].we);
            chk({tbl[i].nm, " mem_to_reg"}, mem_to_reg_o, tbl[i].m2r);
        end

        // EX/MEM forward into SUB
        drive(enc_r(7'h00, 2, 1, 0, 5), 1'b0);
        drive(enc_r(7'h20, 1, 5, 0, 6), 1'b0);
        drive(32'h0, 1'b0);
        chk("s1 alu_op", alu_op_o, 1);
        chk("s1 fwd_a", alu_forward_a_o, 2'b10);
        chk("s1 fwd_b", alu_forward_b_o, 2'b00);
        drive(32'h0, 1'b0);
        chk("s1 rd_we", rd_we_o, 1);
        chk("s1 mem_to_reg", mem_to_reg_o, 0);

        // Load-use: single stall then MEM/WB forward
        drive(enc_i(12'h0, 1, 2, 7, 7'h03), 1'b0);
        drive(enc_r(7'h00, 7, 7, 0, 8), 1'b0);
        chk("s2 stall pc_en", pc_en_o, 0);
        chk("s2 stall if_id_en", if_id_en_o, 0);
        drive(enc_r(7'h00, 7, 7, 0, 8), 1'b0);
        chk("s2 resume pc_en", pc_en_o, 1);
        chk("s2 resume if_id_en", if_id_en_o, 1);
        drive(32'h0, 1'b0);
        chk("s2 fwd_a", alu_forward_a_o, 2'b01);
        chk("s2 fwd_b", alu_forward_b_o, 2'b01);
        chk("s2 mem_to_reg", mem_to_reg_o, 1);
        chk("s2 rd_we", rd_we_o, 1);

        // ALU result feeding a taken branch: stall beats redirect
        drive(enc_i(12'h1, 0, 0, 9, 7'h13), 1'b0);
        drive(enc_b(9, 9, 0), 1'b1);
        chk("s3 stall pc_en", pc_en_o, 0);
        chk("s3 stall pc_next_sel", pc_next_sel_o, 0);
        chk("s3 stall flush", if_id_flush_o, 0);
        drive(enc_b(9, 9, 0), 1'b1);
        chk("s3 bfwd_a", branch_forward_a_o, 1);
        chk("s3 bfwd_b", branch_forward_b_o, 1);
        chk("s3 pc_next_sel", pc_next_sel_o, 1);
        chk("s3 flush", if_id_flush_o, 1);
        chk("s3 pc_operand", pc_operand_o, 0);

        // Store byte lanes on consecutive cycles
        repeat (3) drive(32'h0, 1'b0);
        drive(enc_s(2, 1, 0), 1'b0);
        drive(enc_s(2, 1, 1), 1'b0);
        drive(enc_s(2, 1, 2), 1'b0);
        chk("s4 SB", data_mem_we_o, 4'b0001);
        drive(32'h0, 1'b0);
        chk("s4 SH", data_mem_we_o, 4'b0011);
        drive(32'h0, 1'b0);
        chk("s4 SW", data_mem_we_o, 4'b1111);

        // Jumps never write rd; illegal opcode is inert
        drive(enc_i(12'h0, 3, 0, 0, 7'h67), 1'b0);
        chk("s5 jalr sel", pc_next_sel_o, 1);
        chk("s5 jalr operand", pc_operand_o, 1);
        repeat (3) begin
            drive(32'h0, 1'b0);
            chk("s5 jalr rd_we", rd_we_o, 0);
        end
        drive({20'h00020, 5'd1, 7'h6F}, 1'b0);
        chk("s5 jal sel", pc_next_sel_o, 1);
        chk("s5 jal operand", pc_operand_o, 0);
        repeat (3) begin
            drive(32'h0, 1'b0);
            chk("s5 jal rd_we", rd_we_o, 0);
        end
        drive(32'h0000007F, 1'b1);
        chk("s5 ill sel", pc_next_sel_o, 0);
        chk("s5 ill flush", if_id_flush_o, 0);
        repeat (3) begin
            drive(32'h0, 1'b0);
            chk("s5 ill rd_we", rd_we_o, 0);
            chk("s5 ill mem_we", data_mem_we_o, 0);
        end

        // Random stream; the stalled instruction is held like a real IF/ID
        cur = 32'h0;
        hold = 1'b0;
        for (int k = 0; k < 800; k++) begin
            if (!hold) cur = rand_instr();
            @(posedge clk);
            #1;
            instruction_i = cur;
            branch_condition_i = 1'($urandom_range(0, 1));
            if (k == 400) rst_n = 1'b0;
            if (k == 401) rst_n = 1'b1;
            @(negedge clk);
            chk_all();
            if (k == 400) begin
                chk("midrst alu_op", alu_op_o, 0);
                chk("midrst rd_we", rd_we_o, 0);
                chk("midrst mem_we", data_mem_we_o, 0);
            end
            hold = exp_stall();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
